bin_bcd_conv_param: RTL
=======================

Name: bin_bcd_conv_param

Overview:
Parametrised iterative binary-to-BCD converter (shift-and-add-3, one bit per clock). It generalises the calculator's fixed 16-bit/4-digit converter: BIN_W input width, DIGITS output digits, an overflow flag, busy/done handshake with back-to-back operation, and optional two's-complement input. It sits between the ALU result register and the 7-segment display driver.

Parameters:
BIN_W, 16, input binary width in bits (>=2).
DIGITS, 5, number of BCD output digits (>=1); result width is 4*DIGITS.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  conversion request; sampled only when busy=0.
binary_in  in  BIN_W  value to convert; captured on the edge that accepts start.
bcd_out  out  4*DIGITS  result; digit 0 in [3:0], most significant digit in the top nibble.
busy  out  1  high while a conversion is in progress.
done  out  1  one-cycle pulse when bcd_out/ovf/sign are updated.
ovf  out  1  result did not fit in DIGITS digits.
sign  out  1  negative input (only meaningful with BCD_SIGNED_EN; otherwise 0).

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, bcd_out=0, busy=0, done=0, ovf=0, sign=0, shift register and bit counter=0. Any conversion in progress is aborted and produces no done pulse.
- FSM states: IDLE, CONV.
- IDLE with start=1 at edge E0:
  - Capture the magnitude of binary_in into the binary part of the shift register; clear the BCD part and the overflow accumulator.
  - Set counter=BIN_W, busy=1, go to CONV.
- CONV, each edge:
  - Combinationally add 3 to every BCD digit >=5.
  - Shift the whole register left by 1.
  - If the bit shifted out of the top digit is 1, set the overflow accumulator.
  - Decrement the counter.
- Final shift (counter==1), at edge E0+BIN_W:
  - Register bcd_out, ovf and sign; done=1; busy=0; state=IDLE.
- Timing and throughput:
  - Latency: done is visible after edge E0+BIN_W.
  - done is high for exactly one cycle.
  - start high while done=1 is accepted at the next edge, so back-to-back throughput is one conversion per BIN_W+1 cycles.
- start while busy=1 is ignored; no queuing. Changes to binary_in after capture are ignored.
- bcd_out, ovf and sign hold their last values until the next done pulse.
- Overflow:
  - ovf=1 iff magnitude > 10^DIGITS-1.
  - With ovf=1, bcd_out holds the low DIGITS digits of the true decimal value (modulo 10^DIGITS).
- Width rules:
  - Internal shift register width is 4*DIGITS+BIN_W.
  - Add-3 is applied only to the DIGITS BCD nibbles, never to the binary part.
- Zero input: bcd_out=0, ovf=0, and the full BIN_W-cycle latency still applies (no early exit).

Optional Feature:
Macro BCD_SIGNED_EN.
- Defined: binary_in is two's complement.
  - If binary_in[BIN_W-1]=1, the magnitude (two's-complement negation, treated as an unsigned BIN_W value) is loaded and sign=1 is latched with the result.
  - The most negative value -2^(BIN_W-1) yields magnitude 2^(BIN_W-1) with sign=1.
  - Latency is unchanged.
- Not defined: binary_in is unsigned, the sign port is tied to 0, and no negation logic is present.

Test Plan:
- BIN_W=16, DIGITS=5, binary_in=65535, start pulse -> done exactly 16 edges after the accepting edge; bcd_out=0x65535, ovf=0; busy high for those 16 cycles.
- DIGITS=4: binary_in=9999 -> bcd_out=0x9999, ovf=0. binary_in=12345 -> bcd_out=0x2345, ovf=1. binary_in=0 -> bcd_out=0x0000, ovf=0, latency 16.
- Busy handling, DIGITS=5: start with 1234, then start=1 with 777 during cycle 5 -> ignored, result 0x01234. start held high during the done cycle with 4321 -> accepted; next done 17 cycles after the previous done with 0x04321.
- Reset: assert reset=0 at cycle 8 of a conversion -> busy, done, bcd_out and ovf drop to 0 immediately; no done pulse follows. A new start after reset release converts 42 -> 0x00042.
- BCD_SIGNED_EN, BIN_W=16, DIGITS=5: -1234 (0xFB2E) -> sign=1, bcd_out=0x01234. -32768 -> sign=1, bcd_out=0x32768, ovf=0. 32767 -> sign=0, bcd_out=0x32767.
- BIN_W=8, DIGITS=3, 255 -> bcd_out=0x255, done after 8 edges.

Source files
------------

// File: rtl/bin_bcd_conv_param.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Latency: done pulses BIN_W cycles after the edge that accepts start.
// Backpressure: none; start is ignored while busy, and a start held during done is accepted next edge.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   start      conversion request, sampled only while idle
//   binary_in  value to convert, captured with start
//   bcd_out    DIGITS packed BCD digits, digit 0 in [3:0]
//   busy       conversion in progress
//   done       one-cycle pulse when bcd_out/ovf/sign update
//   ovf        value exceeded 10^DIGITS-1 (bcd_out holds it modulo 10^DIGITS)
//   sign       negative input; only driven when BCD_SIGNED_EN is defined, else tied 0
//
// Optional build macro: BCD_SIGNED_EN -- treat binary_in as two's complement and
// convert its magnitude, latching the sign alongside the result.
module bin_bcd_conv_param #(
    parameter int BIN_W  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [BIN_W-1:0]      binary_in,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  busy,
    output logic                  done,
    output logic                  ovf,
    output logic                  sign
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ovf_acc_q, ovf_acc_d;
    logic [BCD_W-1:0]   bcd_q, bcd_d;
    logic               ovf_q, ovf_d;
    logic               done_q, done_d;

    logic [BIN_W-1:0]   mag;
    logic [SR_W-1:0]    sr_adj;
    logic [SR_W-1:0]    sr_shl;
    logic               top_bit;

`ifdef BCD_SIGNED_EN
    logic neg_q, neg_d;
    logic sign_q, sign_d;
    logic neg_in;

    // Negation is taken modulo 2^BIN_W, so the most negative input maps to
    // 2^(BIN_W-1), which is exactly its unsigned magnitude.
    assign neg_in = binary_in[BIN_W-1];
    assign mag    = neg_in ? (~binary_in + {{(BIN_W-1){1'b0}}, 1'b1}) : binary_in;
`else
    assign mag    = binary_in;
`endif

    // Add-3 correction on the BCD nibbles only; the binary part is untouched.
    always_comb begin
        sr_adj = sr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (sr_q[BIN_W+4*i +: 4] >= 4'd5) begin
                sr_adj[BIN_W+4*i +: 4] = sr_q[BIN_W+4*i +: 4] + 4'd3;
            end
        end
    end

    assign sr_shl  = {sr_adj[SR_W-2:0], 1'b0};
    // A 1 leaving the top digit is a decimal carry that has no digit to land in.
    assign top_bit = sr_adj[SR_W-1];

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        ovf_acc_d = ovf_acc_q;
        bcd_d     = bcd_q;
        ovf_d     = ovf_q;
        done_d    = 1'b0;
`ifdef BCD_SIGNED_EN
        neg_d     = neg_q;
        sign_d    = sign_q;
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d      = {{BCD_W{1'b0}}, mag};
                    cnt_d     = CNT_W'(BIN_W);
                    ovf_acc_d = 1'b0;
`ifdef BCD_SIGNED_EN
                    neg_d     = neg_in;
`endif
                    state_d   = CONV;
                end
            end
            CONV: begin
                sr_d      = sr_shl;
                cnt_d     = cnt_q - CNT_W'(1);
                ovf_acc_d = ovf_acc_q | top_bit;
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = sr_shl[SR_W-1 -: BCD_W];
                    ovf_d   = ovf_acc_q | top_bit;
`ifdef BCD_SIGNED_EN
                    sign_d  = neg_q;
`endif
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            sr_q      <= '0;
            cnt_q     <= '0;
            ovf_acc_q <= 1'b0;
            bcd_q     <= '0;
            ovf_q     <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            ovf_acc_q <= ovf_acc_d;
            bcd_q     <= bcd_d;
            ovf_q     <= ovf_d;
            done_q    <= done_d;
        end
    end

`ifdef BCD_SIGNED_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_q  <= 1'b0;
            sign_q <= 1'b0;
        end else begin
            neg_q  <= neg_d;
            sign_q <= sign_d;
        end
    end

    assign sign = sign_q;
`else
    assign sign = 1'b0;
`endif

    assign bcd_out = bcd_q;
    assign busy    = (state_q == CONV);
    assign done    = done_q;
    assign ovf     = ovf_q;

endmodule
